// File: rtl/awgn_pkg.sv
// Shared taus88 constants, channel state type and step/fix-up helpers for the AWGN uniform generators.
package awgn_pkg;

    localparam logic [31:0] TAUS_MASK1  = 32'hFFFFFFFE;
    localparam logic [31:0] TAUS_MASK2  = 32'hFFFFFFF8;
    localparam logic [31:0] TAUS_MASK3  = 32'hFFFFFFF0;
    localparam logic [31:0] SEED_SPREAD = 32'h9E3779B9;
    localparam logic [31:0] FIX_MIN1    = 32'd2;
    localparam logic [31:0] FIX_MIN2    = 32'd8;
    localparam logic [31:0] FIX_MIN3    = 32'd16;

    // Packed so a {z3,z2,z1} 96-bit word maps straight onto the struct.
    typedef struct packed {
        logic [31:0] z3;
        logic [31:0] z2;
        logic [31:0] z1;
    } taus_state_t;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } fsm_state_e;

    function automatic taus_state_t taus_step(input taus_state_t s);
        taus_state_t r;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        b    = ((s.z1 << 13) ^ s.z1) >> 19;
        r.z1 = ((s.z1 & TAUS_MASK1) << 12) ^ b;
        c    = ((s.z2 << 2) ^ s.z2) >> 25;
        r.z2 = ((s.z2 & TAUS_MASK2) << 4) ^ c;
        d    = ((s.z3 << 3) ^ s.z3) >> 11;
        r.z3 = ((s.z3 & TAUS_MASK3) << 17) ^ d;
        return r;
    endfunction

    // Small seeds would leave a component stuck at zero; force the minimum bit on.
    function automatic taus_state_t taus_fixup(input taus_state_t s);
        taus_state_t r;
        r = s;
        if (s.z1 < FIX_MIN1) r.z1 = s.z1 | FIX_MIN1;
        if (s.z2 < FIX_MIN2) r.z2 = s.z2 | FIX_MIN2;
        if (s.z3 < FIX_MIN3) r.z3 = s.z3 | FIX_MIN3;
        return r;
    endfunction

    function automatic logic [31:0] taus_word(input taus_state_t s);
        return s.z1 ^ s.z2 ^ s.z3;
    endfunction

endpackage

// File: rtl/awgn_taus_core.sv
// One taus88 channel: state register, step logic and a fixed-up seed write port.
module awgn_taus_core
    import awgn_pkg::*;
#(
    parameter logic [31:0] SEED_Z1 = 32'd12345,
    parameter logic [31:0] SEED_Z2 = 32'd67890,
    parameter logic [31:0] SEED_Z3 = 32'd13579
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_i,
    input  logic        load_i,
    input  taus_state_t seed_i,
    output logic [31:0] word_o
);

    localparam taus_state_t RST_STATE = taus_fixup('{z3: SEED_Z3, z2: SEED_Z2, z1: SEED_Z1});

    taus_state_t state_q;
    taus_state_t state_d;
    taus_state_t next_s;

    // A load wins over a step issued in the same cycle.
    always_comb begin
        next_s  = taus_step(state_q);
        state_d = state_q;
        if (load_i) begin
            state_d = taus_fixup(seed_i);
        end else if (step_i) begin
            state_d = next_s;
        end
    end

    assign word_o = taus_word(next_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/awgn_taus_mc.sv
// Multi-channel taus88 URNG with valid/ready output, warm-up FSM and seed reload (AWGN_TAUS_SEED_LOAD_EN).
// Handshake: a sample transfers on a rising edge where out_valid && out_ready; data_out is stable until then.
module awgn_taus_mc
    import awgn_pkg::*;
#(
    parameter int          N_CH   = 4,
    parameter int          OUT_W  = 32,
    parameter int          WARMUP = 16,
    parameter logic [31:0] SEED1  = 32'd12345,
    parameter logic [31:0] SEED2  = 32'd67890,
    parameter logic [31:0] SEED3  = 32'd13579
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [N_CH*OUT_W-1:0]       data_out,
    output logic                        out_valid,
    input  logic                        out_ready
`ifdef AWGN_TAUS_SEED_LOAD_EN
    ,
    input  logic                        seed_valid,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] seed_ch,
    input  logic [95:0]                 seed_data,
    output logic                        seed_ready
`endif
);

    localparam int         CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [7:0] WCNT_LAST = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;
    // With no warm-up the FSM starts (and restarts) directly in RUN so the first sample lands on edge 1.
    localparam fsm_state_e START_ST  = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

    fsm_state_e              state_q;
    logic [7:0]              wcnt_q;
    logic                    out_valid_q;
    logic [N_CH*OUT_W-1:0]   data_out_q;
    logic [N_CH*OUT_W-1:0]   words;
    logic                    adv;
    logic                    seed_acc;
    logic [CH_W-1:0]         load_ch;
    taus_state_t             load_seed;

`ifdef AWGN_TAUS_SEED_LOAD_EN
    logic seed_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_ready_q <= 1'b0;
        end else begin
            seed_ready_q <= 1'b1;
        end
    end

    assign seed_ready = seed_ready_q;
    assign seed_acc   = seed_valid && seed_ready_q;
    assign load_ch    = seed_ch;
    assign load_seed  = seed_data;
`else
    assign seed_acc   = 1'b0;
    assign load_ch    = '0;
    assign load_seed  = '0;
`endif

    assign adv = (state_q == ST_WARMUP) ||
                 ((state_q == ST_RUN) && (!out_valid_q || out_ready));

    // Non-target channels still step on a load cycle when adv is true; the target is overwritten instead.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [31:0] word;
        logic        load_hit;

        assign load_hit = seed_acc && (load_ch == CH_W'(i));

        awgn_taus_core #(
            .SEED_Z1(SEED1 ^ 32'(32'(i) * SEED_SPREAD)),
            .SEED_Z2(SEED2 ^ 32'(32'(i) * SEED_SPREAD)),
            .SEED_Z3(SEED3 ^ 32'(32'(i) * SEED_SPREAD))
        ) u_core (
            .clk    (clk),
            .rst    (rst),
            .step_i (adv),
            .load_i (load_hit),
            .seed_i (load_seed),
            .word_o (word)
        );

        assign words[i*OUT_W +: OUT_W] = word[31 -: OUT_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= START_ST;
            wcnt_q      <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else if (seed_acc) begin
            // Any pending sample is dropped (or was just transferred); all channels re-warm together.
            state_q     <= START_ST;
            wcnt_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    if (wcnt_q == WCNT_LAST) begin
                        state_q <= ST_RUN;
                        wcnt_q  <= '0;
                    end else begin
                        wcnt_q  <= wcnt_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (adv) begin
                        data_out_q  <= words;
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= START_ST;
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_awgn_taus_mc.sv
// Directed bench for awgn_taus_mc: WARMUP=16 main instance plus a WARMUP=0, OUT_W=16 instance.
module tb_awgn_taus_mc;

  localparam int N_CH = 4;
  localparam int OUT_W = 32;
  localparam int WARMUP = 16;
  localparam int DW = N_CH * OUT_W;
  localparam int N0 = 2;
  localparam int W0 = 16;
  localparam int DW0 = N0 * W0;

  typedef struct packed {
    logic rdy;
    logic step;
    logic vld;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0] data_out;
  logic out_valid;
  logic out_ready;
  logic [DW0-1:0] data_out0;
  logic out_valid0;
  logic out_ready0;
`ifdef AWGN_TAUS_SEED_LOAD_EN
  logic seed_valid;
  logic [1:0] seed_ch;
  logic [95:0] seed_data;
  logic seed_ready;
  logic seed_valid0;
  logic [0:0] seed_ch0;
  logic [95:0] seed_data0;
  logic seed_ready0;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit w0_on = 1'b0;
  logic [95:0] ms[N_CH];
  logic [95:0] ms0[N0];
  logic [DW-1:0] exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  awgn_taus_mc #(.N_CH(N_CH), .OUT_W(OUT_W), .WARMUP(WARMUP)) u_dut (
    .clk(clk), .rst(rst), .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready)
`ifdef AWGN_TAUS_SEED_LOAD_EN
    , .seed_valid(seed_valid), .seed_ch(seed_ch), .seed_data(seed_data), .seed_ready(seed_ready)
`endif
  );

  awgn_taus_mc #(.N_CH(N0), .OUT_W(W0), .WARMUP(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .data_out(data_out0), .out_valid(out_valid0), .out_ready(out_ready0)
`ifdef AWGN_TAUS_SEED_LOAD_EN
    , .seed_valid(seed_valid0), .seed_ch(seed_ch0), .seed_data(seed_data0), .seed_ready(seed_ready0)
`endif
  );

  // Reference taus88, written in the style of the C model.
  function automatic logic [95:0] ref_next(input logic [95:0] s);
    logic [31:0] z1, z2, z3, b;
    z1 = s[31:0];
    z2 = s[63:32];
    z3 = s[95:64];
    b = ((z1 << 13) ^ z1) >> 19;
    z1 = ((z1 & 32'hFFFFFFFE) << 12) ^ b;
    b = ((z2 << 2) ^ z2) >> 25;
    z2 = ((z2 & 32'hFFFFFFF8) << 4) ^ b;
    b = ((z3 << 3) ^ z3) >> 11;
    z3 = ((z3 & 32'hFFFFFFF0) << 17) ^ b;
    return {z3, z2, z1};
  endfunction

  function automatic logic [31:0] ref_word(input logic [95:0] s);
    return s[31:0] ^ s[63:32] ^ s[95:64];
  endfunction

  function automatic logic [95:0] ref_seed(input int ch);
    logic [31:0] sp, z1, z2, z3;
    sp = 32'(32'(ch) * 32'h9E3779B9);
    z1 = 32'd12345 ^ sp;
    z2 = 32'd67890 ^ sp;
    z3 = 32'd13579 ^ sp;
    if (z1 < 32'd2) z1 = z1 | 32'd2;
    if (z2 < 32'd8) z2 = z2 | 32'd8;
    if (z3 < 32'd16) z3 = z3 | 32'd16;
    return {z3, z2, z1};
  endfunction

  function automatic logic [DW-1:0] main_exp();
    logic [DW-1:0] r;
    for (int ch = 0; ch < N_CH; ch++) r[ch*OUT_W +: OUT_W] = ref_word(ms[ch]);
    return r;
  endfunction

  function automatic logic [DW0-1:0] w0_exp();
    logic [DW0-1:0] r;
    logic [31:0] w;
    for (int ch = 0; ch < N0; ch++) begin
      w = ref_word(ms0[ch]);
      r[ch*W0 +: W0] = w[31:16];
    end
    return r;
  endfunction

  task automatic init_models();
    for (int ch = 0; ch < N_CH; ch++) ms[ch] = ref_seed(ch);
    for (int ch = 0; ch < N0; ch++) ms0[ch] = ref_seed(ch);
  endtask

  task automatic step_main();
    for (int ch = 0; ch < N_CH; ch++) ms[ch] = ref_next(ms[ch]);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Clock/reset advance: one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (w0_on) begin
      for (int ch = 0; ch < N0; ch++) ms0[ch] = ref_next(ms0[ch]);
      chk("w0_valid", DW'(out_valid0), DW'(1'b1));
      chk("w0_data", DW'(data_out0), DW'(w0_exp()));
    end
  endtask

  // Driver + scoreboard for one edge of the main instance.
  task automatic run_edge(input vec_t v, input string tag);
    logic hs;
    logic [DW-1:0] acc;
    out_ready = v.rdy;
    hs = out_valid && v.rdy;
    acc = data_out;
    tick();
    if (hs) begin
      if (exp_q.size() == 0) chk({tag, "_accept_q"}, DW'(0), DW'(1));
      else chk({tag, "_accept"}, acc, exp_q.pop_front());
    end
    if (v.step) begin
      step_main();
      if (v.vld) exp_q.push_back(main_exp());
    end
    chk({tag, "_valid"}, DW'(out_valid), DW'(v.vld));
    if (v.vld && exp_q.size() > 0) chk({tag, "_data"}, data_out, exp_q[$]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < WARMUP; i++) tbl.push_back('{rdy: 1'b1, step: 1'b1, vld: 1'b0});
    for (int i = 0; i < 100; i++) tbl.push_back('{rdy: 1'b1, step: 1'b1, vld: 1'b1});
    tbl.push_back('{rdy: 1'b1, step: 1'b1, vld: 1'b1});
    tbl.push_back('{rdy: 1'b0, step: 1'b0, vld: 1'b1});
    tbl.push_back('{rdy: 1'b0, step: 1'b0, vld: 1'b1});
    tbl.push_back('{rdy: 1'b1, step: 1'b1, vld: 1'b1});
    tbl.push_back('{rdy: 1'b0, step: 1'b0, vld: 1'b1});
    tbl.push_back('{rdy: 1'b0, step: 1'b0, vld: 1'b1});
    tbl.push_back('{rdy: 1'b1, step: 1'b1, vld: 1'b1});
    tbl.push_back('{rdy: 1'b1, step: 1'b1, vld: 1'b1});
    tbl.push_back('{rdy: 1'b0, step: 1'b0, vld: 1'b1});
    tbl.push_back('{rdy: 1'b1, step: 1'b1, vld: 1'b1});
    tbl.push_back('{rdy: 1'b0, step: 1'b0, vld: 1'b1});
    tbl.push_back('{rdy: 1'b1, step: 1'b1, vld: 1'b1});

    rst = 1'b1;
    out_ready = 1'b1;
    out_ready0 = 1'b1;
`ifdef AWGN_TAUS_SEED_LOAD_EN
    seed_valid = 1'b0;
    seed_ch = '0;
    seed_data = '0;
    seed_valid0 = 1'b0;
    seed_ch0 = '0;
    seed_data0 = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", DW'(out_valid), DW'(0));
    chk("rst_data", data_out, DW'(0));
    chk("rst_w0_valid", DW'(out_valid0), DW'(0));
    chk("rst_w0_data", DW'(data_out0), DW'(0));
`ifdef AWGN_TAUS_SEED_LOAD_EN
    chk("rst_seed_ready", DW'(seed_ready), DW'(0));
`endif
    init_models();
    rst = 1'b0;
    w0_on = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_edge(tbl[i], "tbl");
    chk("stall_qsize", DW'(exp_q.size()), DW'(1));

`ifdef AWGN_TAUS_SEED_LOAD_EN
    chk("seed_ready_run", DW'(seed_ready), DW'(1));
    // Seed {0,0,0} to channel 2 while stalled: the presented sample is dropped.
    out_ready = 1'b0;
    seed_valid = 1'b1;
    seed_ch = 2'd2;
    seed_data = 96'd0;
    tick();
    seed_valid = 1'b0;
    exp_q.delete();
    ms[2] = {32'd16, 32'd8, 32'd2};
    chk("seed_valid_drop", DW'(out_valid), DW'(0));
    for (int i = 0; i < WARMUP; i++) run_edge('{rdy: 1'b1, step: 1'b1, vld: 1'b0}, "seedwu");
    for (int i = 0; i < 6; i++) run_edge('{rdy: 1'b1, step: 1'b1, vld: 1'b1}, "seedrun");

    // Seed load coincident with a handshake on channel 0.
    seed_valid = 1'b1;
    seed_ch = 2'd0;
    seed_data = {32'd1, 32'd5, 32'hDEADBEEF};
    run_edge('{rdy: 1'b1, step: 1'b0, vld: 1'b0}, "coinc");
    seed_valid = 1'b0;
    for (int ch = 1; ch < N_CH; ch++) ms[ch] = ref_next(ms[ch]);
    ms[0] = {32'd17, 32'd13, 32'hDEADBEEF};
    chk("coinc_qsize", DW'(exp_q.size()), DW'(0));
    for (int i = 0; i < WARMUP; i++) run_edge('{rdy: 1'b1, step: 1'b1, vld: 1'b0}, "coincwu");
    for (int i = 0; i < 6; i++) run_edge('{rdy: 1'b1, step: 1'b1, vld: 1'b1}, "coincrun");
`endif

    // Mid-stream reset for half a cycle: outputs clear at once, sequence restarts.
    rst = 1'b1;
    #1;
    chk("mrst_valid", DW'(out_valid), DW'(0));
    chk("mrst_data", data_out, DW'(0));
    chk("mrst_w0_valid", DW'(out_valid0), DW'(0));
    chk("mrst_w0_data", DW'(data_out0), DW'(0));
`ifdef AWGN_TAUS_SEED_LOAD_EN
    chk("mrst_seed_ready", DW'(seed_ready), DW'(0));
`endif
    #2;
    rst = 1'b0;
    exp_q.delete();
    init_models();
    for (int i = 0; i < WARMUP; i++) run_edge('{rdy: 1'b1, step: 1'b1, vld: 1'b0}, "rstwu");
    for (int i = 0; i < 8; i++) run_edge('{rdy: 1'b1, step: 1'b1, vld: 1'b1}, "rstrun");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
